read_arbiter: RTL and testbench

READ_ARBITER -- requirements
Module: read_arbiter

---
 rtl/read_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_read_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_arbiter.sv
// Read arbiter: picks one of N requesting ports per cycle (strict priority or
// weighted round robin), issues the SRAM read, and returns the read data to
// the winning port after the SRAM latency using a {valid, port id} tag pipeline.
module read_arbiter #(
    parameter int arbiter_data_width = 256,
    parameter int num_of_ports       = 16,
    parameter int addr_width         = 12,
    parameter int rd_latency         = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sp0_wrr1,
    input  logic [num_of_ports-1:0]              req_p,
    input  logic [num_of_ports*addr_width-1:0]   addr_p,
    input  logic [num_of_ports*4-1:0]            weight_p,
    output logic [num_of_ports-1:0]              gnt_p,
    output logic                                 sram_rd_en,
    output logic [addr_width-1:0]                sram_rd_addr,
    input  logic [arbiter_data_width-1:0]        sram_rd_data,
    output logic [arbiter_data_width-1:0]        data_out,
    output logic [num_of_ports-1:0]              data_vld_p
);

    localparam int N   = num_of_ports;
    localparam int AW  = addr_width;
    localparam int DW  = arbiter_data_width;
    localparam int L   = rd_latency;
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    // Request / grant stage
    logic [N-1:0]   r_gnt;
    logic           r_rd_en;
    logic [AW-1:0]  r_rd_addr;
    logic [IDW-1:0] r_gnt_id;

    // WRR state and mode tracking
    logic [IDW-1:0] r_ptr;
    logic [3:0]     r_credit;
    logic           r_mode;
    logic           r_mode_vld;

    // Tag pipeline and return stage
    logic           r_tag_vld [L];
    logic [IDW-1:0] r_tag_id  [L];
    logic [DW-1:0]  r_data;
    logic [N-1:0]   r_data_vld;

    // Combinational arbitration results
    logic           w_any;
    logic [IDW-1:0] w_sp_win;
    logic           w_sp_found;
    logic [IDW-1:0] w_rr_win;
    logic           w_rr_found;
    logic [3:0]     w_ptr_weight;
    logic [3:0]     w_ptr_lim;
    logic           w_ptr_req;
    logic           w_keep;
    logic [IDW-1:0] w_win;
    logic [N-1:0]   w_win_onehot;
    logic [AW-1:0]  w_win_addr;
    logic [N-1:0]   w_ret_onehot;
    logic           w_mode_change;

    // Strict priority: lowest-index requester wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the loop can leave it unassigned and infer a latch.
        w_sp_win   = '0;
        w_sp_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_sp_found && req_p[i]) begin
                w_sp_win   = IDW'(i);
                w_sp_found = 1'b1;
            end
        end
    end

    // Weight and request of the port currently holding the WRR pointer.
    always_comb begin
        w_ptr_weight = '0;
        w_ptr_req    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == r_ptr) begin
                w_ptr_weight = weight_p[i*4 +: 4];
                w_ptr_req    = req_p[i];
            end
        end
        // A zero weight still grants one read per turn.
        w_ptr_lim = (w_ptr_weight == 4'd0) ? 4'd1 : w_ptr_weight;
        w_keep    = w_ptr_req && (r_credit < w_ptr_lim);
    end

    // WRR hand-off: first requester circularly after ptr (ptr itself is last).
    always_comb begin
        int idx;
        w_rr_win   = r_ptr;
        w_rr_found = 1'b0;
        idx        = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_rr_found && req_p[idx]) begin
                w_rr_win   = IDW'(idx);
                w_rr_found = 1'b1;
            end
        end
    end

    // Final winner, its one-hot grant and its address.
    always_comb begin
        w_any         = |req_p;
        w_mode_change = r_mode_vld && (sp0_wrr1 != r_mode);
        if (sp0_wrr1) w_win = w_keep ? r_ptr : w_rr_win;
        else          w_win = w_sp_win;
        w_win_onehot = '0;
        w_win_addr   = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == w_win) begin
                w_win_onehot[i] = 1'b1;
                w_win_addr      = addr_p[i*AW +: AW];
            end
        end
    end

    // One-hot of the port id leaving the last tag stage.
    always_comb begin
        w_ret_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == r_tag_id[L-1]) w_ret_onehot[i] = 1'b1;
        end
    end

    // Grant register, SRAM request and WRR pointer/credit update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt      <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_gnt_id   <= '0;
            r_ptr      <= '0;
            r_credit   <= '0;
            r_mode     <= 1'b0;
            r_mode_vld <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side sees the pre-edge value regardless of order.
            r_mode     <= sp0_wrr1;
            r_mode_vld <= 1'b1;
            if (w_any) begin
                r_gnt     <= w_win_onehot;
                r_rd_en   <= 1'b1;
                r_rd_addr <= w_win_addr;
                r_gnt_id  <= w_win;
            end else begin
                r_gnt   <= '0;
                r_rd_en <= 1'b0;
            end
            // A mode switch restarts the credit count; the pointer survives.
            // The grant on the switch edge does not advance WRR state.
            if (w_mode_change) begin
                r_credit <= '0;
            end else if (sp0_wrr1 && w_any) begin
                if (w_keep) begin
                    r_credit <= r_credit + 4'd1;
                end else begin
                    r_ptr    <= w_rr_win;
                    r_credit <= 4'd1;
                end
            end
        end
    end

    // Tag pipeline tracking each issued read through the SRAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the tag stages are reset (unlike a data RAM) so that reads
            // in flight at reset can never return after it is released.
            for (int k = 0; k < L; k++) begin
                r_tag_vld[k] <= 1'b0;
                r_tag_id[k]  <= '0;
            end
        end else begin
            r_tag_vld[0] <= r_rd_en;
            r_tag_id[0]  <= r_gnt_id;
            for (int k = L - 1; k >= 1; k--) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

    // Return stage: capture SRAM data when the matching tag arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_data_vld <= '0;
        end else if (r_tag_vld[L-1]) begin
            r_data     <= sram_rd_data;
            r_data_vld <= w_ret_onehot;
        end else begin
            r_data_vld <= '0;
        end
    end

    assign gnt_p        = r_gnt;
    assign sram_rd_en   = r_rd_en;
    assign sram_rd_addr = r_rd_addr;
    assign data_out     = r_data;
    assign data_vld_p   = r_data_vld;

endmodule

// File: tb/tb_read_arbiter.sv
// Testbench for read_arbiter: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural arbitration model.
module tb_read_arbiter;

    localparam int N  = 16;
    localparam int AW = 12;
    localparam int DW = 256;
    localparam int L  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sp0_wrr1 = 1'b0;
    logic [N-1:0]      req_p = '0;
    logic [N*AW-1:0]   addr_p = '0;
    logic [N*4-1:0]    weight_p = '0;
    logic [N-1:0]      gnt_p;
    logic              sram_rd_en;
    logic [AW-1:0]     sram_rd_addr;
    logic [DW-1:0]     sram_rd_data;
    logic [DW-1:0]     data_out;
    logic [N-1:0]      data_vld_p;

    read_arbiter #(
        .arbiter_data_width(DW),
        .num_of_ports(N),
        .addr_width(AW),
        .rd_latency(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sp0_wrr1(sp0_wrr1),
        .req_p(req_p),
        .addr_p(addr_p),
        .weight_p(weight_p),
        .gnt_p(gnt_p),
        .sram_rd_en(sram_rd_en),
        .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data),
        .data_out(data_out),
        .data_vld_p(data_vld_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] gnt;
        logic [AW-1:0] addr;
    } gnt_exp_t;

    typedef struct {
        int            cyc;
        logic [N-1:0]  vld;
        logic [DW-1:0] data;
    } dat_exp_t;

    gnt_exp_t gq[$];
    dat_exp_t dq[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM contents are a fixed function of the address.
    function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++)
            r[w*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ (32'(w) << 24) ^ 32'h0F0F_1234;
        return r;
    endfunction

    // SRAM model: data appears exactly L cycles after the read strobe, junk otherwise.
    logic [DW-1:0] s_pipe [L];
    always @(posedge clk) begin
        s_pipe[0] <= sram_rd_en ? sram_word(sram_rd_addr) : {8{$urandom}};
        for (int k = 1; k < L; k++) s_pipe[k] <= s_pipe[k-1];
    end
    assign sram_rd_data = s_pipe[L-1];

    // Reference model state
    int   m_ptr = 0;
    int   m_credit = 0;
    logic m_prev_mode = 1'b0;
    bit   m_prev_valid = 1'b0;

    function automatic int wrr_limit(input int p);
        int w;
        w = int'(weight_p[p*4 +: 4]);
        return (w == 0) ? 1 : w;
    endfunction

    // Model one rising edge using the inputs currently driven.
    task automatic model_edge();
        int win;
        bit keep;
        win  = -1;
        keep = 1'b0;
        if (req_p != '0) begin
            if (!sp0_wrr1) begin
                for (int i = N - 1; i >= 0; i--) if (req_p[i]) win = i;
            end else if (req_p[m_ptr] && m_credit < wrr_limit(m_ptr)) begin
                win  = m_ptr;
                keep = 1'b1;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (win < 0 && req_p[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            gq.push_back('{cyc + 1, N'(1) << win, addr_p[win*AW +: AW]});
            dq.push_back('{cyc + 2 + L, N'(1) << win, sram_word(addr_p[win*AW +: AW])});
        end
        if (m_prev_valid && sp0_wrr1 != m_prev_mode) begin
            m_credit = 0;
        end else if (sp0_wrr1 && win >= 0) begin
            if (keep) m_credit = m_credit + 1;
            else begin
                m_ptr    = win;
                m_credit = 1;
            end
        end
        m_prev_mode  = sp0_wrr1;
        m_prev_valid = 1'b1;
    endtask

    // Drive one cycle of inputs (sampled at the next rising edge) and model it.
    task automatic cycle(input logic mode, input logic [N-1:0] req,
                         input logic [N*AW-1:0] a, input logic [N*4-1:0] w);
        @(negedge clk);
        #1;
        sp0_wrr1 = mode;
        req_p    = req;
        addr_p   = a;
        weight_p = w;
        model_edge();
    endtask

    // Hold reset for n rising edges; in-flight reads are forgotten.
    task automatic apply_reset(input int n, input logic mode);
        @(negedge clk);
        #1;
        rst      = 1'b1;
        req_p    = '0;
        sp0_wrr1 = mode;
        gq.delete();
        dq.delete();
        m_ptr        = 0;
        m_credit     = 0;
        m_prev_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b0;
        model_edge();
    endtask

    function automatic logic [N*AW-1:0] rand_addrs();
        logic [N*AW-1:0] r;
        for (int i = 0; i < N; i++) r[i*AW +: AW] = AW'($urandom);
        return r;
    endfunction

    function automatic logic [N*4-1:0] rand_weights();
        logic [N*4-1:0] r;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'($urandom_range(0, 5));
        return r;
    endfunction

    // Monitor: compares DUT outputs against the scoreboard queues.
    gnt_exp_t      ge;
    dat_exp_t      de;
    logic [DW-1:0] last_data = '0;
    logic [AW-1:0] last_addr = '0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_gnt", gnt_p, '0);
            check("rst_rd_en", sram_rd_en, '0);
            check("rst_rd_addr", sram_rd_addr, '0);
            check("rst_data_out", data_out, '0);
            check("rst_data_vld", data_vld_p, '0);
            last_data = '0;
            last_addr = '0;
        end else begin
            if (gnt_p != '0 || sram_rd_en) begin
                if (gq.size() == 0) begin
                    check("gnt_spurious", {gnt_p, sram_rd_en}, '0);
                end else begin
                    ge = gq.pop_front();
                    check("gnt_onehot", gnt_p, ge.gnt);
                    check("gnt_rd_en", sram_rd_en, 1'b1);
                    check("gnt_rd_addr", sram_rd_addr, ge.addr);
                    check("gnt_cycle", cyc, ge.cyc);
                end
                last_addr = sram_rd_addr;
            end else begin
                check("rd_addr_hold", sram_rd_addr, last_addr);
            end
            if (data_vld_p != '0) begin
                if (dq.size() == 0) begin
                    check("data_spurious", data_vld_p, '0);
                end else begin
                    de = dq.pop_front();
                    check("data_vld", data_vld_p, de.vld);
                    check("data_value", data_out, de.data);
                    check("data_cycle", cyc, de.cyc);
                end
                last_data = data_out;
            end else begin
                check("data_hold", data_out, last_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N*AW-1:0] a;
        logic [N*4-1:0]  w;
        logic [N-1:0]    req;
        logic            mode;

        apply_reset(3, 1'b0);

        // Strict priority with ports 2 and 4 requesting: port 2 every cycle.
        a = rand_addrs();
        w = '0;
        repeat (12) cycle(1'b0, 16'h0014, a, w);

        // WRR with weights 2/1/3 on ports 0/1/3 from a fresh reset.
        w = '0;
        w[0*4 +: 4] = 4'd2;
        w[1*4 +: 4] = 4'd1;
        w[3*4 +: 4] = 4'd3;
        apply_reset(2, 1'b1);
        repeat (24) cycle(1'b1, 16'h000B, a, w);

        // Zero weights and pointer wrap between ports 15 and 0.
        w = '0;
        repeat (12) cycle(1'b1, 16'h8001, a, w);

        // Mode switch while port 3 holds credit 2.
        w = '0;
        w[1*4 +: 4] = 4'd1;
        w[3*4 +: 4] = 4'd3;
        for (int i = 0; i < 40 && !(m_ptr == 3 && m_credit == 2); i++)
            cycle(1'b1, 16'h000A, a, w);
        repeat (3) cycle(1'b0, 16'h000A, a, w);
        repeat (8) cycle(1'b1, 16'h000A, a, w);

        // Reset while a read is in flight.
        cycle(1'b1, 16'h0010, a, w);
        apply_reset(2, 1'b1);
        repeat (L + 3) cycle(1'b1, '0, a, w);

        // Idle stretch.
        repeat (10) cycle(1'b0, '0, a, w);

        // Randomized traffic with mode flips, weight changes and rare resets.
        mode = 1'b0;
        w    = rand_weights();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 31) == 0) w = rand_weights();
            a = rand_addrs();
            case ($urandom_range(0, 3))
                0:       req = '0;
                1:       req = N'($urandom);
                2:       req = N'(1) << $urandom_range(0, N - 1);
                default: req = N'($urandom) & N'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) apply_reset(2, mode);
            else cycle(mode, req, a, w);
        end

        repeat (L + 4) cycle(1'b0, '0, a, w);
        @(negedge clk);
        #1;
        check("gnt_queue_left", gq.size(), 0);
        check("data_queue_left", dq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
